// File: rtl/task_sched_if.sv
// task_sched_if: launch inputs, datapath handshake and display outputs of task_sched
interface task_sched_if #(parameter int DATA_W = 8);
  logic start, sel, done1, done2, found2, s1, s2, busy, valid, err;
  logic [DATA_W-1:0] operand, a_out;
  logic [3:0] result1, hex1_val, hex0_val;
  logic [4:0] loc2;
  modport master(
    output start, sel, operand, done1, result1, done2, found2, loc2,
    input s1, s2, a_out, hex1_val, hex0_val, busy, valid, err
  );
  modport slave(
    input start, sel, operand, done1, result1, done2, found2, loc2,
    output s1, s2, a_out, hex1_val, hex0_val, busy, valid, err
  );
endinterface

// File: rtl/task_sched.sv
// task_sched: sequences task1/task2 datapaths and latches their results; TASK_SCHED_AUTO_RERUN_EN relaunches on held switch changes
module task_sched #(
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  task_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic start_q, sel_r, sel_n, s1_n, s2_n, valid_n, err_n, busy_n, launch, done_x, tmo;
  logic [DATA_W-1:0] a_n;
  logic [7:0] hex_n;
  assign done_x = sel_r ? bus.done2 : bus.done1;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign busy_n = state_n != IDLE;
`ifdef TASK_SCHED_AUTO_RERUN_EN
  // a_out and sel_r already hold the operand/sel captured at the last launch
  logic diff, diff_q;
  assign diff = state == IDLE && bus.valid && (bus.operand != bus.a_out || bus.sel != sel_r);
  assign launch = (bus.start && !start_q) || (diff && diff_q);
  // remembers that the switches differed from the last launch on the previous cycle
  always_ff @(posedge clk) diff_q <= reset ? 1'b0 : diff;
`else
  assign launch = bus.start && !start_q;
`endif
  // next-state and next-output logic; done beats a coincident timeout
  always_comb begin
    state_n = state;
    cnt_n = state == IDLE ? cnt : cnt + 1'b1;
    sel_n = sel_r;
    a_n = bus.a_out;
    s1_n = bus.s1;
    s2_n = bus.s2;
    valid_n = bus.valid;
    err_n = bus.err;
    hex_n = {bus.hex1_val, bus.hex0_val};
    case (state)
      IDLE: if (launch) begin
        state_n = RUN;
        cnt_n = '0;
        sel_n = bus.sel;
        a_n = bus.operand;
        s1_n = !bus.sel;
        s2_n = bus.sel;
        valid_n = 1'b0;
        err_n = 1'b0;
      end
      RUN: if (done_x || tmo) begin
        state_n = RELEASE;
        cnt_n = '0;
        s1_n = 1'b0;
        s2_n = 1'b0;
        valid_n = done_x;
        err_n = !done_x;
        hex_n = !done_x ? 8'hEE : !sel_r ? {4'h0, bus.result1} : bus.found2 ? {3'b000, bus.loc2} : 8'hFF;
      end
      RELEASE: if (!done_x) state_n = IDLE;
      else if (tmo) begin
        state_n = IDLE;
        valid_n = 1'b0;
        err_n = 1'b1;
        hex_n = 8'hEE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      start_q <= 1'b0;
      sel_r <= 1'b0;
      bus.s1 <= 1'b0;
      bus.s2 <= 1'b0;
      bus.a_out <= '0;
      bus.hex1_val <= 4'h0;
      bus.hex0_val <= 4'h0;
      bus.busy <= 1'b0;
      bus.valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      start_q <= bus.start;
      sel_r <= sel_n;
      bus.s1 <= s1_n;
      bus.s2 <= s2_n;
      bus.a_out <= a_n;
      {bus.hex1_val, bus.hex0_val} <= hex_n;
      bus.busy <= busy_n;
      bus.valid <= valid_n;
      bus.err <= err_n;
    end
endmodule

// File: tb/tb_task_sched.sv
// tb_task_sched: randomized and directed runs of task_sched checked against a transaction-level model
module tb_task_sched;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  task_sched_if #(.DATA_W(8)) bus();
  task_sched #(.DATA_W(8), .TIMEOUT_CYCLES(TO)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_s"}, {bus.s1, bus.s2}, 0);
    check({tag, "_a"}, bus.a_out, 0);
    check({tag, "_hex"}, {bus.hex1_val, bus.hex0_val}, 0);
    check({tag, "_flags"}, {bus.busy, bus.valid, bus.err}, 0);
  endtask
  // one complete run: done returned after d RUN cycles, or never if d >= TO
  task automatic run_one(input logic sel, input logic [7:0] op, input logic [3:0] res,
                         input logic found, input logic [4:0] loc, input int d,
                         input bit hold, input bit noise);
    logic [7:0] e;
    e = sel ? (found ? {3'b000, loc} : 8'hFF) : {4'h0, res};
    bus.sel = sel;
    bus.operand = op;
    bus.start = 1'b1;
    tick();
    check("launch_s1", bus.s1, !sel);
    check("launch_s2", bus.s2, sel);
    check("launch_a", bus.a_out, op);
    check("launch_flags", {bus.busy, bus.valid, bus.err}, 3'b100);
    bus.start = hold;
    for (int i = 1; i <= (d < TO ? d : TO); i++) begin
      if (noise) begin
        bus.sel = 1'($urandom);
        bus.operand = 8'($urandom);
        if (!hold) bus.start = 1'($urandom);
        if (sel) bus.done1 = 1'($urandom);
        else bus.done2 = 1'($urandom);
      end
      tick();
      check("run_s", bus.s1 | bus.s2, i < TO);
      check("run_a", bus.a_out, op);
    end
    bus.sel = sel;
    bus.operand = op;
    bus.start = hold;
    bus.done1 = 1'b0;
    bus.done2 = 1'b0;
    if (d >= TO) begin
      check("tmo_flags", {bus.busy, bus.valid, bus.err}, 3'b101);
      check("tmo_hex", {bus.hex1_val, bus.hex0_val}, 8'hEE);
      tick();
      check("tmo_idle", {bus.busy, bus.err, bus.s1, bus.s2}, 4'b0100);
    end else begin
      bus.result1 = res;
      bus.found2 = found;
      bus.loc2 = loc;
      if (sel) bus.done2 = 1'b1;
      else bus.done1 = 1'b1;
      tick();
      check("done_s", {bus.s1, bus.s2}, 0);
      check("done_flags", {bus.busy, bus.valid, bus.err}, 3'b110);
      check("done_hex", {bus.hex1_val, bus.hex0_val}, e);
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("rel_busy", {bus.busy, bus.s1, bus.s2}, 3'b100);
      end
      bus.done1 = 1'b0;
      bus.done2 = 1'b0;
      tick();
      check("idle_flags", {bus.busy, bus.valid, bus.err}, 3'b010);
      check("idle_hex", {bus.hex1_val, bus.hex0_val}, e);
    end
    if (hold) begin
      repeat (3) begin
        tick();
        check("hold_norun", {bus.busy, bus.s1, bus.s2}, 0);
      end
      bus.start = 1'b0;
      tick();
    end
  endtask
  initial begin
    {bus.start, bus.sel, bus.done1, bus.done2, bus.found2} = '0;
    bus.operand = '0;
    bus.result1 = '0;
    bus.loc2 = '0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    run_one(1'b0, 8'hA7, 4'd5, 1'b0, 5'd0, 3, 1'b0, 1'b0);
    run_one(1'b1, 8'h3C, 4'd0, 1'b1, 5'd27, 4, 1'b0, 1'b0);
    run_one(1'b1, 8'h3C, 4'd0, 1'b0, 5'd27, 2, 1'b0, 1'b0);
    run_one(1'b0, 8'h55, 4'd9, 1'b0, 5'd0, 45, 1'b1, 1'b0);
    run_one(1'b0, 8'h12, 4'd7, 1'b0, 5'd0, 0, 1'b1, 1'b0);
    run_one(1'b1, 8'h99, 4'd0, 1'b1, 5'd3, TO - 1, 1'b0, 1'b1);
    run_one(1'b1, 8'h44, 4'd0, 1'b1, 5'd1, TO + 4, 1'b0, 1'b0);
    run_one(1'b0, 8'h66, 4'd2, 1'b0, 5'd0, 5, 1'b0, 1'b1);
    repeat (40) run_one(1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 5'($urandom),
                        $urandom_range(0, TO + 4), 1'($urandom), 1'($urandom));
    bus.sel = 1'b1;
    bus.operand = 8'h77;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.done1 = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_zero("midreset");
    reset = 1'b0;
    bus.done1 = 1'b0;
    tick();
    run_one(1'b0, 8'h01, 4'd1, 1'b0, 5'd0, 2, 1'b0, 1'b0);
    bus.operand = 8'h03;
    tick();
    tick();
`ifdef TASK_SCHED_AUTO_RERUN_EN
    check("rerun_s1", bus.s1, 1);
    check("rerun_a", bus.a_out, 8'h03);
`else
    check("norerun_s1", {bus.busy, bus.s1}, 0);
    check("norerun_a", bus.a_out, 8'h01);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
